instr_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU datapath (8x8 reg_file, ALU, 2s-complement/immediate muxes, PC). It owns the PC and the instruction register, and steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK or BRANCH. It handshakes with a variable-latency instruction memory and issues the single-cycle register write strobe. It also resolves beq/j redirects and detects illegal opcodes and instruction-fetch timeouts.

---
 rtl/instr_sequencer_if.sv | 27 ++
 rtl/instr_sequencer.sv | 109 ++++++++++
 tb/tb_instr_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-sequencer bus: IMEM fetch handshake, ALU flag in, control/debug outputs.
// IMEM handshake: the sequencer holds IMEM_READ high in FETCH; INSTRUCTION is taken on any rising edge where IMEM_BUSY is low.
interface instr_sequencer_if #(
   parameter int PC_WIDTH = 32
);
   logic [31:0]         INSTRUCTION;
   logic                IMEM_BUSY;
   logic                ZERO;
   logic                IMEM_READ;
   logic [PC_WIDTH-1:0] PC;
   logic [31:0]         IR;
   logic                REG_WE;
   logic                BRANCH_TAKEN;
   logic                ILLEGAL;
   logic                FAULT;
   logic [2:0]          STATE;

   modport slave (
      input  INSTRUCTION, IMEM_BUSY, ZERO,
      output IMEM_READ, PC, IR, REG_WE, BRANCH_TAKEN, ILLEGAL, FAULT, STATE
   );

   modport master (
      output INSTRUCTION, IMEM_BUSY, ZERO,
      input  IMEM_READ, PC, IR, REG_WE, BRANCH_TAKEN, ILLEGAL, FAULT, STATE
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, steps FETCH/DECODE/EXECUTE/WRITEBACK|BRANCH,
// resolves beq/j redirects, flags illegal opcodes and latches a sticky fetch-timeout fault.
module instr_sequencer #(
   parameter int                  PC_WIDTH      = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
   parameter int                  FETCH_TIMEOUT = 15
) (
   input  logic               CLK,
   input  logic               RESET,
   instr_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_BRANCH    = 3'd4,
      S_FAULT     = 3'd7
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [31:0]         r_ir;
   logic [7:0]          r_cnt;
   logic                r_branch_taken;
   logic                r_illegal;

   logic [7:0]          w_opcode;
   logic [7:0]          w_cnt_inc;
   logic                w_timeout;
   logic                w_taken;
   logic [PC_WIDTH-1:0] w_pc_plus4;
   logic [PC_WIDTH-1:0] w_offset;
   logic [PC_WIDTH-1:0] w_target;

   assign w_opcode   = r_ir[31:24];
   assign w_cnt_inc  = r_cnt + 8'd1;
   assign w_timeout  = (w_cnt_inc == 8'(FETCH_TIMEOUT));
   assign w_taken    = (w_opcode == 8'd7) || ((w_opcode == 8'd6) && bus.ZERO);
   assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
   // Signed instruction offset, scaled to bytes; sums wrap modulo 2^PC_WIDTH.
   assign w_offset   = {{(PC_WIDTH-10){r_ir[23]}}, r_ir[23:16], 2'b00};
   assign w_target   = w_pc_plus4 + w_offset;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (!bus.IMEM_BUSY)  w_next_state = S_DECODE;
            else if (w_timeout)  w_next_state = S_FAULT;
         end
         S_DECODE:    w_next_state = (w_opcode > 8'd7) ? S_FETCH : S_EXECUTE;
         S_EXECUTE:   w_next_state = (w_opcode <= 8'd5) ? S_WRITEBACK : S_BRANCH;
         S_WRITEBACK: w_next_state = S_FETCH;
         S_BRANCH:    w_next_state = S_FETCH;
         S_FAULT:     w_next_state = S_FAULT;
         default:     w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state        <= S_FETCH;
         r_pc           <= RESET_PC;
         r_ir           <= 32'd0;
         r_cnt          <= 8'd0;
         r_branch_taken <= 1'b0;
         r_illegal      <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_branch_taken <= 1'b0;
         r_illegal      <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!bus.IMEM_BUSY) begin
                  r_ir  <= bus.INSTRUCTION;
                  r_cnt <= 8'd0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_DECODE: begin
               if (w_opcode > 8'd7) begin
                  r_pc      <= w_pc_plus4;
                  r_illegal <= 1'b1;
               end
            end
            S_WRITEBACK: r_pc <= w_pc_plus4;
            S_BRANCH: begin
               r_pc           <= w_taken ? w_target : w_pc_plus4;
               r_branch_taken <= w_taken;
            end
            default: ;
         endcase
      end
   end

   assign bus.IMEM_READ    = (r_state == S_FETCH);
   assign bus.REG_WE       = (r_state == S_WRITEBACK);
   assign bus.FAULT        = (r_state == S_FAULT);
   assign bus.PC           = r_pc;
   assign bus.IR           = r_ir;
   assign bus.BRANCH_TAKEN = r_branch_taken;
   assign bus.ILLEGAL      = r_illegal;
   assign bus.STATE        = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: IMEM is modelled by driving INSTRUCTION/IMEM_BUSY per cycle.
module tb_instr_sequencer;

   logic CLK;
   logic RESET;
   int   checks;
   int   failures;
   int   we_cnt;
   int   bt_cnt;

   instr_sequencer_if #(.PC_WIDTH(32)) bus();

   instr_sequencer #(.PC_WIDTH(32), .RESET_PC(32'd0), .FETCH_TIMEOUT(15)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.REG_WE === 1'b1) we_cnt++;
      if (bus.BRANCH_TAKEN === 1'b1) bt_cnt++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      bus.IMEM_BUSY = 1'b1;
      tick();
      RESET = 1'b0;
      we_cnt = 0;
      bt_cnt = 0;
   endtask

   // Present one instruction after busy_n wait cycles, then run DECODE/EXECUTE/closing edge.
   task automatic run_instr(input logic [31:0] instr, input int busy_n);
      bus.IMEM_BUSY = 1'b1;
      for (int i = 0; i < busy_n; i++) tick();
      bus.INSTRUCTION = instr;
      bus.IMEM_BUSY   = 1'b0;
      tick();
      bus.IMEM_BUSY   = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.STATE !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.STATE); end
      checks++; if (bus.PC !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.PC); end
      checks++; if (bus.IR !== 32'd0) begin failures++; $display("FAIL reset_ir got=%h exp=0", bus.IR); end
      checks++; if ({bus.IMEM_READ, bus.REG_WE, bus.BRANCH_TAKEN, bus.ILLEGAL, bus.FAULT} !== 5'b10000) begin
         failures++; $display("FAIL reset_flags got=%b exp=10000", {bus.IMEM_READ, bus.REG_WE, bus.BRANCH_TAKEN, bus.ILLEGAL, bus.FAULT});
      end
   endtask

   task automatic test_loadi();
      logic [2:0] exp_st [4];
      logic       exp_we [4];
      exp_st = '{3'd1, 3'd2, 3'd3, 3'd0};
      exp_we = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      bus.INSTRUCTION = 32'h05020005;
      bus.IMEM_BUSY   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.IMEM_BUSY = 1'b1;
         checks++; if (bus.STATE !== exp_st[i]) begin failures++; $display("FAIL loadi_state[%0d] got=%0d exp=%0d", i, bus.STATE, exp_st[i]); end
         checks++; if (bus.REG_WE !== exp_we[i]) begin failures++; $display("FAIL loadi_we[%0d] got=%b exp=%b", i, bus.REG_WE, exp_we[i]); end
         if (i < 3) begin
            checks++; if (bus.PC !== 32'd0) begin failures++; $display("FAIL loadi_pc_hold[%0d] got=%h exp=0", i, bus.PC); end
         end
      end
      checks++; if (bus.PC !== 32'd4) begin failures++; $display("FAIL loadi_pc got=%h exp=4", bus.PC); end
      checks++; if (bus.IR !== 32'h05020005) begin failures++; $display("FAIL loadi_ir got=%h exp=05020005", bus.IR); end
      checks++; if (we_cnt !== 1) begin failures++; $display("FAIL loadi_we_count got=%0d exp=1", we_cnt); end
   endtask

   task automatic test_fetch_wait();
      do_reset();
      bus.IMEM_BUSY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.STATE !== 3'd0 || bus.IMEM_READ !== 1'b1 || bus.PC !== 32'd0) begin
            failures++; $display("FAIL wait_hold[%0d] got state=%0d rd=%b pc=%h exp state=0 rd=1 pc=0", i, bus.STATE, bus.IMEM_READ, bus.PC);
         end
      end
      bus.INSTRUCTION = 32'h00010203;
      bus.IMEM_BUSY   = 1'b0;
      tick();
      bus.IMEM_BUSY   = 1'b1;
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL wait_decode got=%0d exp=1", bus.STATE); end
      tick();
      tick();
      tick();
      checks++; if (bus.PC !== 32'd4) begin failures++; $display("FAIL wait_pc got=%h exp=4", bus.PC); end
      checks++; if (bus.IR !== 32'h00010203) begin failures++; $display("FAIL wait_ir got=%h exp=00010203", bus.IR); end
      checks++; if (we_cnt !== 1) begin failures++; $display("FAIL wait_we_count got=%0d exp=1", we_cnt); end
      checks++; if (bus.FAULT !== 1'b0) begin failures++; $display("FAIL wait_fault got=%b exp=0", bus.FAULT); end
   endtask

   task automatic test_beq_taken();
      run_instr(32'h00010203, 0);           // PC 4 -> 8
      checks++; if (bus.PC !== 32'd8) begin failures++; $display("FAIL beq_t_setup_pc got=%h exp=8", bus.PC); end
      we_cnt   = 0;
      bt_cnt   = 0;
      bus.ZERO = 1'b1;
      run_instr(32'h06FE0102, 0);
      checks++; if (bus.PC !== 32'd4) begin failures++; $display("FAIL beq_t_pc got=%h exp=4", bus.PC); end
      checks++; if (bus.BRANCH_TAKEN !== 1'b1) begin failures++; $display("FAIL beq_t_pulse got=%b exp=1", bus.BRANCH_TAKEN); end
      tick();
      checks++; if (bus.BRANCH_TAKEN !== 1'b0) begin failures++; $display("FAIL beq_t_pulse_end got=%b exp=0", bus.BRANCH_TAKEN); end
      checks++; if (bt_cnt !== 1) begin failures++; $display("FAIL beq_t_pulse_count got=%0d exp=1", bt_cnt); end
      checks++; if (we_cnt !== 0) begin failures++; $display("FAIL beq_t_we got=%0d exp=0", we_cnt); end
   endtask

   task automatic test_beq_not_taken();
      run_instr(32'h00010203, 0);           // PC 4 -> 8
      we_cnt   = 0;
      bt_cnt   = 0;
      bus.ZERO = 1'b0;
      run_instr(32'h06FE0102, 0);
      checks++; if (bus.PC !== 32'd12) begin failures++; $display("FAIL beq_nt_pc got=%h exp=c", bus.PC); end
      tick();
      checks++; if (bt_cnt !== 0) begin failures++; $display("FAIL beq_nt_pulse got=%0d exp=0", bt_cnt); end
      checks++; if (we_cnt !== 0) begin failures++; $display("FAIL beq_nt_we got=%0d exp=0", we_cnt); end
   endtask

   task automatic test_jump();
      do_reset();
      bus.ZERO = 1'b0;
      run_instr(32'h07030000, 0);
      checks++; if (bus.PC !== 32'd16) begin failures++; $display("FAIL j_pc got=%h exp=10", bus.PC); end
      checks++; if (bus.BRANCH_TAKEN !== 1'b1) begin failures++; $display("FAIL j_pulse got=%b exp=1", bus.BRANCH_TAKEN); end
      // Negative offset from PC 0 wraps below zero.
      do_reset();
      bus.ZERO = 1'b1;
      run_instr(32'h07FE0000, 2);
      checks++; if (bus.PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL j_wrap_pc got=%h exp=fffffffc", bus.PC); end
      run_instr(32'h05020005, 0);
      checks++; if (bus.PC !== 32'd0) begin failures++; $display("FAIL wb_wrap_pc got=%h exp=0", bus.PC); end
   endtask

   task automatic test_illegal();
      do_reset();
      bus.ZERO = 1'b0;
      run_instr(32'h07030000, 0);           // PC -> 16
      we_cnt = 0;
      bus.INSTRUCTION = 32'h09000000;
      bus.IMEM_BUSY   = 1'b0;
      tick();
      bus.IMEM_BUSY   = 1'b1;
      checks++; if (bus.STATE !== 3'd1 || bus.PC !== 32'd16) begin
         failures++; $display("FAIL ill_decode got state=%0d pc=%h exp state=1 pc=10", bus.STATE, bus.PC);
      end
      tick();
      checks++; if (bus.STATE !== 3'd0) begin failures++; $display("FAIL ill_state got=%0d exp=0", bus.STATE); end
      checks++; if (bus.PC !== 32'd20) begin failures++; $display("FAIL ill_pc got=%h exp=14", bus.PC); end
      checks++; if (bus.ILLEGAL !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b exp=1", bus.ILLEGAL); end
      tick();
      checks++; if (bus.ILLEGAL !== 1'b0) begin failures++; $display("FAIL ill_pulse_end got=%b exp=0", bus.ILLEGAL); end
      checks++; if (we_cnt !== 0) begin failures++; $display("FAIL ill_we got=%0d exp=0", we_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      run_instr(32'h05020005, 0);           // PC -> 4, counter clear
      bus.IMEM_BUSY = 1'b1;
      for (int i = 1; i <= 14; i++) tick();
      checks++; if (bus.STATE !== 3'd0 || bus.FAULT !== 1'b0) begin
         failures++; $display("FAIL to_early got state=%0d fault=%b exp state=0 fault=0", bus.STATE, bus.FAULT);
      end
      tick();
      checks++; if (bus.STATE !== 3'd7) begin failures++; $display("FAIL to_state got=%0d exp=7", bus.STATE); end
      checks++; if (bus.FAULT !== 1'b1 || bus.IMEM_READ !== 1'b0) begin
         failures++; $display("FAIL to_flags got fault=%b rd=%b exp fault=1 rd=0", bus.FAULT, bus.IMEM_READ);
      end
      bus.IMEM_BUSY   = 1'b0;
      bus.INSTRUCTION = 32'h00010203;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (bus.STATE !== 3'd7 || bus.PC !== 32'd4 || bus.IR !== 32'h05020005) begin
         failures++; $display("FAIL to_sticky got state=%0d pc=%h ir=%h exp state=7 pc=4 ir=05020005", bus.STATE, bus.PC, bus.IR);
      end
      do_reset();
      checks++; if (bus.STATE !== 3'd0 || bus.PC !== 32'd0 || bus.FAULT !== 1'b0) begin
         failures++; $display("FAIL to_reset got state=%0d pc=%h fault=%b exp state=0 pc=0 fault=0", bus.STATE, bus.PC, bus.FAULT);
      end
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      run_instr(32'h00010203, 0);           // PC -> 4 so reset visibly clears it
      we_cnt = 0;
      bus.INSTRUCTION = 32'h01010203;
      bus.IMEM_BUSY   = 1'b0;
      tick();
      bus.IMEM_BUSY   = 1'b1;
      tick();
      checks++; if (bus.STATE !== 3'd2) begin failures++; $display("FAIL rst_mid_exec got=%0d exp=2", bus.STATE); end
      #2;
      RESET = 1'b1;
      #1;
      checks++; if (bus.STATE !== 3'd0 || bus.PC !== 32'd0 || bus.IR !== 32'd0 || bus.IMEM_READ !== 1'b1 || bus.REG_WE !== 1'b0) begin
         failures++; $display("FAIL rst_mid_async got state=%0d pc=%h ir=%h rd=%b we=%b exp state=0 pc=0 ir=0 rd=1 we=0",
                              bus.STATE, bus.PC, bus.IR, bus.IMEM_READ, bus.REG_WE);
      end
      tick();
      tick();
      RESET = 1'b0;
      checks++; if (we_cnt !== 0) begin failures++; $display("FAIL rst_mid_we got=%0d exp=0", we_cnt); end
      run_instr(32'h00040506, 0);
      checks++; if (bus.PC !== 32'd4 || bus.IR !== 32'h00040506) begin
         failures++; $display("FAIL rst_mid_restart got pc=%h ir=%h exp pc=4 ir=00040506", bus.PC, bus.IR);
      end
      checks++; if (we_cnt !== 1) begin failures++; $display("FAIL rst_mid_restart_we got=%0d exp=1", we_cnt); end
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      we_cnt          = 0;
      bt_cnt          = 0;
      RESET           = 1'b1;
      bus.INSTRUCTION = 32'd0;
      bus.IMEM_BUSY   = 1'b1;
      bus.ZERO        = 1'b0;
      #2;
      test_reset();
      test_loadi();
      test_fetch_wait();
      test_beq_taken();
      test_beq_not_taken();
      test_jump();
      test_illegal();
      test_timeout();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
